// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path.
// Holds the OpCode/Funct values recognised by the decoder.
// Holds the FSM state encoding and the instruction classes.
// Holds the datapath mux-select codes (PCSource, ALUSrcA/B, RegDst, MemtoReg)
// and the ALUOp operation codes consumed by the ALU control.
package cpu_ctrl_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_RTYPE   = 4'd0,
        C_SHIFT   = 4'd1,
        C_ITYPE   = 4'd2,
        C_LW      = 4'd3,
        C_SW      = 4'd4,
        C_BEQ     = 4'd5,
        C_J       = 4'd6,
        C_JAL     = 4'd7,
        C_JR      = 4'd8,
        C_JALR    = 4'd9,
        C_ILLEGAL = 4'd10
    } iclass_t;

    localparam logic [2:0] PCSRC_ALU    = 3'd0;
    localparam logic [2:0] PCSRC_ALUOUT = 3'd1;
    localparam logic [2:0] PCSRC_JUMP   = 3'd2;
    localparam logic [2:0] PCSRC_REG    = 3'd3;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_REG   = 2'd1;
    localparam logic [1:0] SRCA_SHAMT = 2'd2;

    localparam logic [1:0] SRCB_REG       = 2'd0;
    localparam logic [1:0] SRCB_FOUR      = 2'd1;
    localparam logic [1:0] SRCB_IMM       = 2'd2;
    localparam logic [1:0] SRCB_IMM_SHIFT = 2'd3;

    localparam logic [1:0] RDST_RT = 2'd0;
    localparam logic [1:0] RDST_RD = 2'd1;
    localparam logic [1:0] RDST_RA = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    // ALUOp codes; ALUOP_FUNCT defers to the Funct field in the ALU control
    localparam logic [3:0] ALUOP_ADD   = 4'd0;
    localparam logic [3:0] ALUOP_SUB   = 4'd1;
    localparam logic [3:0] ALUOP_FUNCT = 4'd2;
    localparam logic [3:0] ALUOP_AND   = 4'd3;
    localparam logic [3:0] ALUOP_OR    = 4'd4;
    localparam logic [3:0] ALUOP_XOR   = 4'd5;
    localparam logic [3:0] ALUOP_SLT   = 4'd6;
    localparam logic [3:0] ALUOP_SLTU  = 4'd7;
    localparam logic [3:0] ALUOP_LUI   = 4'd8;

    // Shift-by-shamt R-type functions take their A operand from the shamt field
    function automatic logic funct_is_shift(input logic [5:0] funct);
        return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder for the multi-cycle control FSM.
// Ports:
//   op_code  in  6  IR[31:26]
//   funct    in  6  IR[5:0]
//   iclass   out    instruction class steering the FSM
//   ext_op   out 1  1 = sign-extend the immediate
//   lui_op   out 1  1 = immediate goes to the upper half
//   alu_op   out 4  ALU operation class
//   illegal  out 1  1 = OpCode/Funct outside the supported instruction set
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    output iclass_t    iclass,
    output logic       ext_op,
    output logic       lui_op,
    output logic [3:0] alu_op,
    output logic       illegal
);

    // Map OpCode/Funct to class, immediate extension mode and ALU operation
    always_comb begin
        iclass = C_ILLEGAL;
        ext_op = 1'b0;
        lui_op = 1'b0;
        alu_op = ALUOP_ADD;
        case (op_code)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL, FN_SRL, FN_SRA,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR,
                    FN_SLT, FN_SLTU: begin
                        iclass = funct_is_shift(funct) ? C_SHIFT : C_RTYPE;
                        alu_op = ALUOP_FUNCT;
                    end
                    FN_JR:   iclass = C_JR;
                    FN_JALR: iclass = C_JALR;
                    default: iclass = C_ILLEGAL;
                endcase
            end
            OP_J:   iclass = C_J;
            OP_JAL: iclass = C_JAL;
            OP_BEQ: begin
                iclass = C_BEQ;
                ext_op = 1'b1;
                alu_op = ALUOP_SUB;
            end
            OP_ADDI, OP_ADDIU: begin
                iclass = C_ITYPE;
                ext_op = 1'b1;
                alu_op = ALUOP_ADD;
            end
            OP_SLTI: begin
                iclass = C_ITYPE;
                ext_op = 1'b1;
                alu_op = ALUOP_SLT;
            end
            OP_SLTIU: begin
                iclass = C_ITYPE;
                ext_op = 1'b1;
                alu_op = ALUOP_SLTU;
            end
            OP_ANDI: begin
                iclass = C_ITYPE;
                alu_op = ALUOP_AND;
            end
            OP_ORI: begin
                iclass = C_ITYPE;
                alu_op = ALUOP_OR;
            end
            OP_XORI: begin
                iclass = C_ITYPE;
                alu_op = ALUOP_XOR;
            end
            OP_LUI: begin
                iclass = C_ITYPE;
                lui_op = 1'b1;
                alu_op = ALUOP_LUI;
            end
            OP_LW: begin
                iclass = C_LW;
                ext_op = 1'b1;
            end
            OP_SW: begin
                iclass = C_SW;
                ext_op = 1'b1;
            end
            default: iclass = C_ILLEGAL;
        endcase
    end

    assign illegal = (iclass == C_ILLEGAL);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS CPU: sequences IF/ID/EX/MEM/WB and
// drives every datapath strobe and mux select. Only the state is registered;
// all outputs decode combinationally from state, OpCode and Funct, and are
// forced to zero while reset is low.
// Optional feature macro: MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN
//   defined   - unknown instructions take the S_TRAP path to the exception vector
//   undefined - unknown instructions retire from S_ID as a NOP
// Ports:
//   clk, reset (async active-low)
//   OpCode, Funct  instruction register fields
//   Zero           ALU zero flag (qualification happens in the datapath)
//   mem_ready      memory completes current access this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite  strobes
//   RegDst, MemtoReg, ExtOp, LuiOp, ALUSrcA, ALUSrcB, ALUOp, PCSource  selects
//   retire         one-cycle pulse in the last cycle of each instruction
module multi_cycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int         ALUOP_W    = 4,
    parameter logic [2:0] TRAP_PCSRC = 3'd4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         OpCode,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         RegDst,
    output logic [1:0]         MemtoReg,
    output logic               ExtOp,
    output logic               LuiOp,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [2:0]         PCSource,
    output logic               retire
);

    state_t     state_r;
    state_t     next_state_s;
    iclass_t    iclass_s;
    logic       dec_ext_s;
    logic       dec_lui_s;
    logic       dec_illegal_s;
    logic [3:0] dec_alu_op_s;
    logic [3:0] alu_op_s;
    logic       unused_zero_s;

    // Zero is consumed by the datapath's PCWriteCond gating, not by the FSM
    assign unused_zero_s = Zero;

    ctrl_decode u_decode (
        .op_code (OpCode),
        .funct   (Funct),
        .iclass  (iclass_s),
        .ext_op  (dec_ext_s),
        .lui_op  (dec_lui_s),
        .alu_op  (dec_alu_op_s),
        .illegal (dec_illegal_s)
    );

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IF;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and output decode
    always_comb begin
        next_state_s = state_r;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = RDST_RT;
        MemtoReg     = M2R_ALUOUT;
        ExtOp        = 1'b0;
        LuiOp        = 1'b0;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_REG;
        alu_op_s     = ALUOP_ADD;
        PCSource     = PCSRC_ALU;
        retire       = 1'b0;

        if (!reset) begin
            // Everything stays at zero while reset is held
            next_state_s = S_IF;
        end else begin
            case (state_r)
                S_IF: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    if (mem_ready) begin
                        IRWrite      = 1'b1;
                        PCWrite      = 1'b1;
                        next_state_s = S_ID;
                    end else begin
                        next_state_s = S_IF;
                    end
                end

                S_ID: begin
                    // Branch target precomputed into ALUOut
                    ALUSrcB = SRCB_IMM_SHIFT;
                    ExtOp   = 1'b1;
                    if (dec_illegal_s) begin
`ifdef MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN
                        next_state_s = S_TRAP;
`else
                        retire       = 1'b1;
                        next_state_s = S_IF;
`endif
                    end else begin
                        case (iclass_s)
                            C_J, C_JAL: begin
                                PCWrite      = 1'b1;
                                PCSource     = PCSRC_JUMP;
                                retire       = 1'b1;
                                next_state_s = S_IF;
                                if (iclass_s == C_JAL) begin
                                    RegWrite = 1'b1;
                                    RegDst   = RDST_RA;
                                    MemtoReg = M2R_PC;
                                end else begin
                                    RegWrite = 1'b0;
                                end
                            end
                            C_JR, C_JALR: begin
                                PCWrite      = 1'b1;
                                PCSource     = PCSRC_REG;
                                retire       = 1'b1;
                                next_state_s = S_IF;
                                if (iclass_s == C_JALR) begin
                                    RegWrite = 1'b1;
                                    RegDst   = RDST_RD;
                                    MemtoReg = M2R_PC;
                                end else begin
                                    RegWrite = 1'b0;
                                end
                            end
                            default: next_state_s = S_EX;
                        endcase
                    end
                end

                S_EX: begin
                    ALUSrcA  = SRCA_REG;
                    ExtOp    = dec_ext_s;
                    LuiOp    = dec_lui_s;
                    alu_op_s = dec_alu_op_s;
                    case (iclass_s)
                        C_RTYPE: begin
                            ALUSrcB      = SRCB_REG;
                            next_state_s = S_WB;
                        end
                        C_SHIFT: begin
                            ALUSrcA      = SRCA_SHAMT;
                            ALUSrcB      = SRCB_REG;
                            next_state_s = S_WB;
                        end
                        C_ITYPE: begin
                            ALUSrcB      = SRCB_IMM;
                            next_state_s = S_WB;
                        end
                        C_LW, C_SW: begin
                            ALUSrcB      = SRCB_IMM;
                            next_state_s = S_MEM;
                        end
                        C_BEQ: begin
                            ALUSrcB      = SRCB_REG;
                            PCWriteCond  = 1'b1;
                            PCSource     = PCSRC_ALUOUT;
                            retire       = 1'b1;
                            next_state_s = S_IF;
                        end
                        default: next_state_s = S_IF;
                    endcase
                end

                S_MEM: begin
                    IorD  = 1'b1;
                    ExtOp = dec_ext_s;
                    LuiOp = dec_lui_s;
                    if (iclass_s == C_SW) begin
                        MemWrite = 1'b1;
                    end else begin
                        MemRead = 1'b1;
                    end
                    if (!mem_ready) begin
                        next_state_s = S_MEM;
                    end else if (iclass_s == C_SW) begin
                        retire       = 1'b1;
                        next_state_s = S_IF;
                    end else begin
                        next_state_s = S_WB;
                    end
                end

                S_WB: begin
                    RegWrite     = 1'b1;
                    retire       = 1'b1;
                    ExtOp        = dec_ext_s;
                    LuiOp        = dec_lui_s;
                    next_state_s = S_IF;
                    case (iclass_s)
                        C_RTYPE, C_SHIFT: RegDst   = RDST_RD;
                        C_LW:             MemtoReg = M2R_MDR;
                        default:          RegDst   = RDST_RT;
                    endcase
                end

                S_TRAP: begin
                    PCWrite      = 1'b1;
                    PCSource     = TRAP_PCSRC;
                    retire       = 1'b1;
                    next_state_s = S_IF;
                end

                default: next_state_s = S_IF;
            endcase
        end

        ALUOp = ALUOP_W'(alu_op_s);
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: each stimulus cycle pushes the
// hand-derived expected control vector; a negedge monitor pops and compares.
module tb_multi_cycle_ctrl;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       irw;
        logic       rgw;
        logic [1:0] rdst;
        logic [1:0] m2r;
        logic       ext;
        logic       lui;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [2:0] pcsrc;
        logic       ret;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB;
    logic       ExtOp, LuiOp, retire;
    logic [3:0] ALUOp;
    logic [2:0] PCSource;

    ctl_t  exp_q[$];
    string name_q[$];
    ctl_t  mon_exp;
    ctl_t  mon_act;
    string mon_name;
    int    checks = 0;
    int    passes = 0;

    always #5 clk = ~clk;

    multi_cycle_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .OpCode      (OpCode),
        .Funct       (Funct),
        .Zero        (Zero),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .ExtOp       (ExtOp),
        .LuiOp       (LuiOp),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .retire      (retire)
    );

    // Monitor: compare the presented control vector against the scoreboard
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act.pcw   = PCWrite;
            mon_act.pcwc  = PCWriteCond;
            mon_act.iord  = IorD;
            mon_act.mrd   = MemRead;
            mon_act.mwr   = MemWrite;
            mon_act.irw   = IRWrite;
            mon_act.rgw   = RegWrite;
            mon_act.rdst  = RegDst;
            mon_act.m2r   = MemtoReg;
            mon_act.ext   = ExtOp;
            mon_act.lui   = LuiOp;
            mon_act.srca  = ALUSrcA;
            mon_act.srcb  = ALUSrcB;
            mon_act.pcsrc = PCSource;
            mon_act.ret   = retire;
            checks++;
            if (mon_act !== mon_exp) begin
                $display("FAIL %s: got %b required %b", mon_name, mon_act, mon_exp);
            end else begin
                passes++;
            end
        end
    end

    function automatic ctl_t c_if(input logic rdy);
        ctl_t c = '0;
        c.mrd  = 1'b1;
        c.srcb = 2'd1;
        c.pcw  = rdy;
        c.irw  = rdy;
        return c;
    endfunction

    function automatic ctl_t c_id();
        ctl_t c = '0;
        c.srcb = 2'd3;
        c.ext  = 1'b1;
        return c;
    endfunction

    function automatic ctl_t c_ex(input logic [1:0] sa, input logic [1:0] sb,
                                  input logic ext, input logic lui);
        ctl_t c = '0;
        c.srca = sa;
        c.srcb = sb;
        c.ext  = ext;
        c.lui  = lui;
        return c;
    endfunction

    function automatic ctl_t c_mem(input logic wr, input logic ret);
        ctl_t c = '0;
        c.iord = 1'b1;
        c.mrd  = ~wr;
        c.mwr  = wr;
        c.ext  = 1'b1;
        c.ret  = ret;
        return c;
    endfunction

    function automatic ctl_t c_wb(input logic [1:0] rdst, input logic [1:0] m2r,
                                  input logic ext, input logic lui);
        ctl_t c = '0;
        c.rgw  = 1'b1;
        c.ret  = 1'b1;
        c.rdst = rdst;
        c.m2r  = m2r;
        c.ext  = ext;
        c.lui  = lui;
        return c;
    endfunction

    // One clock of stimulus plus its expected control vector
    task automatic step(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                        input logic rdy, input ctl_t e, input string nm);
        @(posedge clk);
        #1;
        reset     = rst;
        OpCode    = op;
        Funct     = fn;
        mem_ready = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic run_alu(input logic [5:0] op, input logic [5:0] fn,
                           input logic [1:0] sa, input logic [1:0] sb,
                           input logic ext, input logic lui,
                           input logic [1:0] rdst, input string nm);
        step(1'b1, op, fn, 1'b1, c_if(1'b1), {nm, "_if"});
        step(1'b1, op, fn, 1'b1, c_id(), {nm, "_id"});
        step(1'b1, op, fn, 1'b1, c_ex(sa, sb, ext, lui), {nm, "_ex"});
        step(1'b1, op, fn, 1'b1, c_wb(rdst, 2'd0, ext, lui), {nm, "_wb"});
    endtask

    initial begin
        ctl_t e;
        reset     = 1'b0;
        OpCode    = 6'h00;
        Funct     = 6'h00;
        Zero      = 1'b1;
        mem_ready = 1'b0;

        // Reset: all strobes and selects zero even with mem_ready high
        step(1'b0, 6'h00, 6'h00, 1'b0, '0, "reset_a");
        step(1'b0, 6'h23, 6'h00, 1'b1, '0, "reset_b");

        // lw with three memory stalls: 8 cycles, mem_ready in EX ignored
        step(1'b1, 6'h23, 6'h00, 1'b1, c_if(1'b1), "lw_if");
        step(1'b1, 6'h23, 6'h00, 1'b1, c_id(), "lw_id");
        step(1'b1, 6'h23, 6'h00, 1'b0, c_ex(2'd1, 2'd2, 1'b1, 1'b0), "lw_ex");
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 6'h23, 6'h00, 1'b0, c_mem(1'b0, 1'b0), "lw_mem_wait");
        end
        step(1'b1, 6'h23, 6'h00, 1'b1, c_mem(1'b0, 1'b0), "lw_mem_done");
        step(1'b1, 6'h23, 6'h00, 1'b1, c_wb(2'd0, 2'd1, 1'b1, 1'b0), "lw_wb");

        // Immediate ALU ops and R-type: four cycles each
        run_alu(6'h0d, 6'h00, 2'd1, 2'd2, 1'b0, 1'b0, 2'd0, "ori");
        run_alu(6'h0f, 6'h00, 2'd1, 2'd2, 1'b0, 1'b1, 2'd0, "lui");
        run_alu(6'h08, 6'h00, 2'd1, 2'd2, 1'b1, 1'b0, 2'd0, "addi");
        run_alu(6'h00, 6'h20, 2'd1, 2'd0, 1'b0, 1'b0, 2'd1, "add");
        run_alu(6'h00, 6'h00, 2'd2, 2'd0, 1'b0, 1'b0, 2'd1, "sll");

        // beq with one fetch stall; retires in S_EX
        step(1'b1, 6'h04, 6'h00, 1'b0, c_if(1'b0), "beq_if_stall");
        step(1'b1, 6'h04, 6'h00, 1'b1, c_if(1'b1), "beq_if");
        step(1'b1, 6'h04, 6'h00, 1'b1, c_id(), "beq_id");
        e = c_ex(2'd1, 2'd0, 1'b1, 1'b0);
        e.pcwc = 1'b1; e.pcsrc = 3'd1; e.ret = 1'b1;
        step(1'b1, 6'h04, 6'h00, 1'b1, e, "beq_ex");

        // jal / j / jr / jalr all retire in S_ID
        step(1'b1, 6'h03, 6'h00, 1'b1, c_if(1'b1), "jal_if");
        e = c_id();
        e.pcw = 1'b1; e.pcsrc = 3'd2; e.rgw = 1'b1; e.rdst = 2'd2; e.m2r = 2'd2; e.ret = 1'b1;
        step(1'b1, 6'h03, 6'h00, 1'b1, e, "jal_id");
        step(1'b1, 6'h02, 6'h00, 1'b1, c_if(1'b1), "j_if");
        e = c_id();
        e.pcw = 1'b1; e.pcsrc = 3'd2; e.ret = 1'b1;
        step(1'b1, 6'h02, 6'h00, 1'b1, e, "j_id");
        step(1'b1, 6'h00, 6'h08, 1'b1, c_if(1'b1), "jr_if");
        e = c_id();
        e.pcw = 1'b1; e.pcsrc = 3'd3; e.ret = 1'b1;
        step(1'b1, 6'h00, 6'h08, 1'b1, e, "jr_id");
        step(1'b1, 6'h00, 6'h09, 1'b1, c_if(1'b1), "jalr_if");
        e = c_id();
        e.pcw = 1'b1; e.pcsrc = 3'd3; e.rgw = 1'b1; e.rdst = 2'd1; e.m2r = 2'd2; e.ret = 1'b1;
        step(1'b1, 6'h00, 6'h09, 1'b1, e, "jalr_id");

        // sw: four cycles
        step(1'b1, 6'h2b, 6'h00, 1'b1, c_if(1'b1), "sw_if");
        step(1'b1, 6'h2b, 6'h00, 1'b1, c_id(), "sw_id");
        step(1'b1, 6'h2b, 6'h00, 1'b1, c_ex(2'd1, 2'd2, 1'b1, 1'b0), "sw_ex");
        step(1'b1, 6'h2b, 6'h00, 1'b1, c_mem(1'b1, 1'b1), "sw_mem");

        // Reset during a stalled sw: MemWrite drops at once, fetch restarts
        step(1'b1, 6'h2b, 6'h00, 1'b1, c_if(1'b1), "swr_if");
        step(1'b1, 6'h2b, 6'h00, 1'b1, c_id(), "swr_id");
        step(1'b1, 6'h2b, 6'h00, 1'b1, c_ex(2'd1, 2'd2, 1'b1, 1'b0), "swr_ex");
        step(1'b1, 6'h2b, 6'h00, 1'b0, c_mem(1'b1, 1'b0), "swr_mem_wait");
        step(1'b0, 6'h2b, 6'h00, 1'b0, '0, "swr_reset_a");
        step(1'b0, 6'h2b, 6'h00, 1'b1, '0, "swr_reset_b");
        step(1'b1, 6'h2b, 6'h00, 1'b0, c_if(1'b0), "post_reset_if");
        step(1'b1, 6'h2b, 6'h00, 1'b1, c_if(1'b1), "post_reset_if_go");
        step(1'b1, 6'h2b, 6'h00, 1'b1, c_id(), "post_reset_id");

        // Unknown opcode 0x3f
        step(1'b1, 6'h2b, 6'h00, 1'b1, c_ex(2'd1, 2'd2, 1'b1, 1'b0), "post_reset_ex");
        step(1'b1, 6'h2b, 6'h00, 1'b1, c_mem(1'b1, 1'b1), "post_reset_mem");
        step(1'b1, 6'h3f, 6'h00, 1'b1, c_if(1'b1), "ill_if");
`ifdef MULTI_CYCLE_CTRL_ILLEGAL_TRAP_EN
        step(1'b1, 6'h3f, 6'h00, 1'b1, c_id(), "ill_id");
        e = '0;
        e.pcw = 1'b1; e.pcsrc = 3'd4; e.ret = 1'b1;
        step(1'b1, 6'h3f, 6'h00, 1'b1, e, "ill_trap");
`else
        e = c_id();
        e.ret = 1'b1;
        step(1'b1, 6'h3f, 6'h00, 1'b1, e, "ill_id_nop");
`endif
        step(1'b1, 6'h00, 6'h00, 1'b0, c_if(1'b0), "after_ill_if");

        // Let the monitor drain, then confirm nothing was left unchecked
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
        end else begin
            passes++;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
